// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data memory between the pipeline
// memory stage (P) and a debug/loader requester (D). Each access is sequenced
// IDLE -> ACCESS (LATENCY cycles) -> DONE, and P is stalled until its own DONE.
// Optional feature macro: MEMARB_ANTISTARVE_EN (forces D in after STARVE_MAX
// consecutive P grants while D waits). Without it P has strict priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // LATENCY is at most 4, so the down-counter never needs more than 2 bits.
    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             owner_d_r;     // 1: current access belongs to D
    logic [CNT_W-1:0] cnt_r;
    logic             grant_s;       // an access is granted this cycle
    logic             grant_d_s;     // ...and D is the winner
    logic             force_d_s;     // anti-starvation overrides P priority

`ifdef MEMARB_ANTISTARVE_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_r;

    assign force_d_s = d_req && (starve_r == STARVE_LIM);

    // Count consecutive P grants taken while D was waiting; any D grant or a
    // cycle without d_req starts the count over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_r <= {STARVE_W{1'b0}};
        end else if (!d_req) begin
            starve_r <= {STARVE_W{1'b0}};
        end else if (grant_s && grant_d_s) begin
            starve_r <= {STARVE_W{1'b0}};
        end else if (grant_s && (starve_r != STARVE_LIM)) begin
            starve_r <= starve_r + STARVE_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end
`else
    // Strict P priority. STARVE_MAX is legal only when >= 1, so this term is
    // always 0; it is referenced so both builds share one parameter list.
    assign force_d_s = (STARVE_MAX < 0) ? d_req : 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and arbitration: grants happen only in IDLE; DONE never
    // grants because p_req there still belongs to the completing instruction.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        grant_d_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (p_req || d_req) begin
                    grant_s     = 1'b1;
                    grant_d_s   = d_req && (!p_req || force_d_s);
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // The grant pulse is combinational with the decision; held low in reset.
    assign d_gnt   = grant_s && grant_d_s && rst_n;
    // P is released only in the DONE cycle of its own access.
    assign p_stall = p_req && !((state_r == DONE) && !owner_d_r);

    // Command registers, latency counter, memory outputs and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            p_rdata   <= {DATA_W{1'b0}};
            d_rdata   <= {DATA_W{1'b0}};
            d_done    <= 1'b0;
        end else begin
            d_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_d_r <= grant_d_s;
                        cnt_r     <= CNT_LOAD;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d_s ? d_we    : p_we;
                        mem_addr  <= grant_d_s ? d_addr  : p_addr;
                        mem_wdata <= grant_d_s ? d_wdata : p_wdata;
                    end else begin
                        mem_en <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        d_done <= owner_d_r;
                        if (!mem_we) begin
                            if (owner_d_r) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                p_rdata <= mem_rdata;
                            end
                        end else begin
                            p_rdata <= p_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model
// (access age, owner, shadow memory) compared every cycle, plus directed cases.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int LATENCY    = 2;
    localparam int STARVE_MAX = 4;
`ifdef MEMARB_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p_req, p_we, d_req, d_we;
    logic [ADDR_W-1:0] p_addr, d_addr;
    logic [DATA_W-1:0] p_wdata, d_wdata;
    logic [DATA_W-1:0] p_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              p_stall, d_gnt, d_done, mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY),
                       .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory (asynchronous read) and the model's shadow copy.
    logic [DATA_W-1:0] env_mem [1024];
    logic [DATA_W-1:0] shadow  [1024];
    assign mem_rdata = env_mem[mem_addr];

    // Reference model state.
    int                age;          // 0 idle, 1..LATENCY access, LATENCY+1 done
    bit                own_d;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] exp_prdata, exp_drdata;
    int                streak;

    int  n_chk, n_pass;
    int  stall_cycles, en_cycles;
    bit  evt_pdone, evt_ddone, evt_pgnt, evt_dgnt;
    bit  p_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        age = 0; own_d = 1'b0; streak = 0;
        exp_prdata = '0; exp_drdata = '0;
    endtask

    // One clock cycle: compare outputs with the model, advance the model,
    // emulate the memory write, then move to the next falling edge.
    task automatic step();
        bit in_acc, in_done, grant, win_d;
        #1;
        in_acc  = (age >= 1) && (age <= LATENCY);
        in_done = (age == LATENCY + 1);
        grant   = (age == 0) && (p_req || d_req);
        win_d   = grant && d_req && (!p_req || (ANTI && streak >= STARVE_MAX));
        chk("mem_en",  32'(mem_en),  32'(in_acc));
        chk("mem_we",  32'(mem_we),  32'(in_acc && cmd_we));
        if (in_acc) begin
            chk("mem_addr",  32'(mem_addr), 32'(cmd_addr));
            chk("mem_wdata", mem_wdata, cmd_wdata);
        end
        chk("p_stall", 32'(p_stall), 32'(p_req && !(in_done && !own_d)));
        chk("d_gnt",   32'(d_gnt),   32'(win_d));
        chk("d_done",  32'(d_done),  32'(in_done && own_d));
        chk("p_rdata", p_rdata, exp_prdata);
        chk("d_rdata", d_rdata, exp_drdata);
        if (mem_en) en_cycles++;
        if (p_stall) stall_cycles++;
        evt_pdone = in_done && !own_d;
        evt_ddone = in_done && own_d;
        evt_pgnt  = grant && !win_d;
        evt_dgnt  = win_d;
        if (grant) begin
            own_d     = win_d;
            cmd_we    = win_d ? d_we : p_we;
            cmd_addr  = win_d ? d_addr : p_addr;
            cmd_wdata = win_d ? d_wdata : p_wdata;
            if (cmd_we) shadow[cmd_addr] = cmd_wdata;
            age = 1;
        end else if (in_done) begin
            age = 0;
        end else if (in_acc) begin
            if (age == LATENCY && !cmd_we) begin
                if (own_d) exp_drdata = shadow[cmd_addr];
                else       exp_prdata = shadow[cmd_addr];
            end
            age++;
        end
        if (!d_req || win_d) streak = 0;
        else if (grant) streak++;
        if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold P inputs until P's DONE; returns cycle count including DONE.
    task automatic run_p(output int cycles);
        cycles = 0;
        evt_pdone = 1'b0;
        while (!evt_pdone && cycles < 50) begin
            step();
            cycles++;
        end
        chk("p_timeout", 32'(evt_pdone), 32'd1);
        p_req = 1'b0;
    endtask

    int  cyc, gnt_at, done_at, n_gnt, pc, pg, dg, p_before, after_d, dd;
    bit  pend_after;

    initial begin
        n_chk = 0; n_pass = 0;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
            shadow[i]  = env_mem[i];
        end
        env_mem[10'h019] = 32'h01354440; shadow[10'h019] = 32'h01354440;
        env_mem[10'h005] = 32'h08438433; shadow[10'h005] = 32'h08438433;
        model_reset();
        rst_n = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        p_busy = 1'b0;
        #3;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_p_rdata", p_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_p_stall_hi", 32'(p_stall), 32'd1);
        p_req = 1'b0; d_req = 1'b0;
        #1;
        chk("rst_p_stall_lo", 32'(p_stall), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();

        // P load of 0x019.
        stall_cycles = 0; en_cycles = 0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 10'h019;
        run_p(cyc);
        chk("pload_stall", 32'(stall_cycles), 32'(LATENCY + 1));
        chk("pload_en", 32'(en_cycles), 32'(LATENCY));
        chk("pload_cycles", 32'(cyc), 32'(LATENCY + 2));
        chk("pload_data", p_rdata, 32'h01354440);

        // P store then P load of 0x019 with the one IDLE cycle in between.
        p_req = 1'b1; p_we = 1'b1; p_addr = 10'h019; p_wdata = 32'h8f3da232;
        run_p(cyc);
        p_req = 1'b1; p_we = 1'b0; p_addr = 10'h019; p_wdata = '0;
        run_p(cyc);
        chk("st_ld_cycles", 32'(cyc), 32'(LATENCY + 2));
        chk("st_ld_data", p_rdata, 32'h8f3da232);

        // D load of 0x005 with P idle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        gnt_at = -1; done_at = -1; n_gnt = 0;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            step();
            if (evt_dgnt) begin n_gnt++; gnt_at = c; d_req = 1'b0; end
            if (evt_ddone) done_at = c;
        end
        chk("dload_gnts", 32'(n_gnt), 32'd1);
        chk("dload_gap", 32'(done_at - gnt_at), 32'(LATENCY + 1));
        chk("dload_data", d_rdata, 32'h08438433);

        // Both requesters held high for 20 P accesses.
        p_req = 1'b1; p_we = 1'b0; p_addr = 10'($urandom_range(0, 15));
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'($urandom_range(0, 15));
        pc = 0; pg = 0; dg = 0; p_before = -1; after_d = 0; pend_after = 1'b0;
        for (int c = 0; c < 400 && pc < 20; c++) begin
            step();
            if ((evt_pgnt || evt_dgnt) && pend_after) begin
                after_d = evt_pgnt ? 1 : 2; pend_after = 1'b0;
            end
            if (evt_pgnt) pg++;
            if (evt_dgnt) begin
                if (dg == 0) begin p_before = pg; pend_after = 1'b1; end
                dg++;
                d_addr = 10'($urandom_range(0, 15));
            end
            if (evt_pdone) begin pc++; p_addr = 10'($urandom_range(0, 15)); end
        end
        chk("starve_p_done", 32'(pc), 32'd20);
`ifdef MEMARB_ANTISTARVE_EN
        chk("starve_p_before_d", 32'(p_before), 32'(STARVE_MAX));
        chk("starve_p_resumes", 32'(after_d), 32'd1);
`else
        chk("starve_no_d", 32'(dg), 32'd0);
`endif
        p_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < LATENCY + 3; c++) step();

        // Reset pulsed in the middle of a D access.
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
        step();
        d_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_d_done", 32'(d_done), 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        dd = 0;
        for (int c = 0; c < LATENCY + 4; c++) begin
            step();
            if (d_done || d_gnt) dd++;
        end
        chk("midrst_no_pulse", 32'(dd), 32'd0);

        // Random traffic.
        p_busy = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!p_busy) begin
                if ($urandom_range(0, 3) == 0) begin
                    p_req = 1'b1; p_busy = 1'b1;
                    p_we = 1'($urandom_range(0, 1));
                    p_addr = 10'($urandom_range(0, 15));
                    p_wdata = $urandom;
                end else begin
                    p_req = 1'b0;
                    p_addr = 10'($urandom_range(0, 1023));
                    p_we = 1'($urandom_range(0, 1));
                end
            end
            if (!d_req) begin
                d_we = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                if ($urandom_range(0, 4) == 0) begin
                    d_req = 1'b1;
                    d_addr = 10'($urandom_range(0, 15));
                end else begin
                    d_addr = 10'($urandom_range(0, 1023));
                end
            end
            step();
            if (evt_pdone) begin p_busy = 1'b0; p_req = 1'b0; end
            if (evt_dgnt) d_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
